coordinate_restorer: RTL and testbench
======================================

// Module: coordinate_restorer
// PURPOSE
//  Inverse of the scale-space coordinate transform: maps keypoint coordinates found at
//  (octave, sublevel) back to base-image pixel coordinates, out = round(in * 2^(oct + sub/L)).
//  Sits between the per-level extrema detectors and descriptor/output stage; streaming,
//  3-stage pipeline with valid/ready backpressure; x and y handled in parallel, tag carried.
// PARAMETERS
//  COORD_BITS        16  integer bits of input and output coordinates
//  FRAC_BITS          2  sub-pixel fraction bits on input coordinates (unsigned fixed point)
//  OCTAVES            4  number of octaves; valid octave 0..OCTAVES-1
//  LEVELS_PER_OCTAVE  3  sublevels per octave; valid sublevel 0..LEVELS_PER_OCTAVE-1
//  SCALE_FRAC        16  fraction bits of the per-sublevel scale constant K[j]
//  TAG_BITS           8  opaque tag carried alongside each coordinate pair
// PORTS
//  clk         in   1                      clock, all state on posedge
//  rst         in   1                      asynchronous, active-high reset
//  in_valid    in   1                      input pair valid
//  in_ready    out  1                      block accepts input this cycle
//  in_x, in_y  in   COORD_BITS+FRAC_BITS   level-space coordinates, unsigned Q(COORD_BITS.FRAC_BITS)
//  in_octave   in   $clog2(OCTAVES)        octave index
//  in_sublevel in   $clog2(LEVELS_PER_OCTAVE) sublevel index
//  in_tag      in   TAG_BITS               passthrough tag
//  out_valid   out  1                      result valid
//  out_ready   in   1                      downstream accepts result
//  out_x,out_y out  COORD_BITS             base-image integer coordinates
//  out_tag     out  TAG_BITS               tag of this result
//  out_sat     out  1                      x or y saturated to 2^COORD_BITS-1
//  out_err     out  1                      octave/sublevel out of range; out_x=out_y=0
// BEHAVIOUR
//  - Reset: out_valid=0, all stage valids=0, out_x/out_y/out_tag/out_sat/out_err=0; in_ready=1
//    while in reset deasserted. Reset mid-operation discards all in-flight items.
//  - Handshake: transfer when valid&&ready on either side. Global advance en = !s2_valid || out_ready;
//    in_ready = en (combinational). Stalled stages hold data; out_* stable while out_valid&&!out_ready.
//    out_valid never drops without a transfer.
//  - Latency 3 cycles accept->out_valid with no stall; throughput 1 pair/cycle.
//  - S0: register inputs; range check (octave>=OCTAVES or sublevel>=L -> err); lookup K[sublevel].
//  - S1: prod = coord * K, width COORD_BITS+FRAC_BITS+SCALE_FRAC+1 bits, unsigned.
//  - S2: v = (prod << octave) + 2^(FRAC_BITS+SCALE_FRAC-1); res = v >> (FRAC_BITS+SCALE_FRAC)
//    (round half up); shift computed without truncation; res > 2^COORD_BITS-1 -> clamp, sat=1.
//    err forces out_x=out_y=0, sat=0.
//  - K[j] = round(2^(j/L) * 2^SCALE_FRAC), elaboration-time constants; defaults 65536, 82570, 104032.
//  - Order preserved; tag unmodified. Simultaneous accept and emit in one cycle when en=1.
// STRUCTURE
//  - Package scale_space_pkg: function scale_const(j, L, SCALE_FRAC), typedef level_coord_t
//    (x,y,octave,sublevel,tag), shared with the forward transformer.
//  - Sub-module coord_scale_lane (one per axis, instanced twice): multiply/shift/round/saturate
//    datapath, stage enables from parent. Parent owns handshake, valids, tag, err.
// TESTING
//  - x=40(10.0),y=0, oct0 sub0 -> out_x=10,out_y=0, sat=0, err=0, out_valid 3 cycles after accept.
//  - x=41(10.25), oct2 sub0 -> out_x=41; x=42(10.5), oct0 sub0 -> 11 (half rounds up).
//  - x=400(100.0), oct0 sub1 -> 126; sub2 -> 159; tags 0x11,0x22 returned in order.
//  - x=262140(65535.0), oct3 sub0 -> out_x=65535, out_sat=1; sub=3 -> out_err=1, out_x=out_y=0.
//  - out_ready low 6 cycles, 5 back-to-back inputs offered -> exactly 3 accepted, in_ready=0,
//    out_* stable; on release all 5 emerge in order, none lost or duplicated.
//  - Assert rst with 3 items in flight -> out_valid=0 immediately; after release, next input
//    produces exactly one result 3 cycles later.

Source files
------------

// File: rtl/scale_space_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scale_space_pkg
//  Description : Shared scale-space types and constants. Used by the forward
//                coordinate transformer and by coordinate_restorer.
//  Revision    : 1.0  initial release
// ============================================================================
package scale_space_pkg;

    localparam int c_lc_coord_w = 16 + 2;   // integer + fraction bits of a level coordinate
    localparam int c_lc_oct_w   = 2;
    localparam int c_lc_sub_w   = 2;
    localparam int c_lc_tag_w   = 8;

    // Keypoint coordinate as seen at one (octave, sublevel) of the pyramid
    typedef struct packed {
        logic [c_lc_coord_w-1:0] x;
        logic [c_lc_coord_w-1:0] y;
        logic [c_lc_oct_w-1:0]   octave;
        logic [c_lc_sub_w-1:0]   sublevel;
        logic [c_lc_tag_w-1:0]   tag;
    } level_coord_t;

    // K[j] = round(2^(j/l) * 2^scale_frac), evaluated with integers only.
    // m = floor(2x) is the largest m with m^l <= 2^(l*(scale_frac+1)+j);
    // round(x) = floor((m+1)/2).
    function automatic longint unsigned scale_const(input int j, input int l, input int scale_frac);
        logic [127:0] target;
        logic [127:0] m;
        logic [127:0] trial;
        logic [127:0] pw;
        target = 128'd1 << (l * (scale_frac + 1) + j);
        m      = '0;
        for (int b = scale_frac + 1; b >= 0; b--) begin
            trial = m | (128'd1 << b);
            pw    = 128'd1;
            for (int i = 0; i < l; i++) begin
                pw = pw * trial;
            end
            if (pw <= target) begin
                m = trial;
            end
        end
        m = (m + 128'd1) >> 1;
        return m[63:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/coord_scale_lane.sv
`default_nettype none
// ============================================================================
//  Module      : coord_scale_lane
//  Description : One axis of the restorer datapath: S0 operand register,
//                S1 multiply by K, S2 octave shift, round half up, saturate.
//  Revision    : 1.0  initial release
// ============================================================================
module coord_scale_lane
    import scale_space_pkg::*;
#(
    parameter int COORD_BITS = 16,
    parameter int FRAC_BITS  = 2,
    parameter int SCALE_FRAC = 16,
    parameter int OCT_W      = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_en,
    input  logic [COORD_BITS+FRAC_BITS-1:0] i_coord,
    input  logic [SCALE_FRAC:0]             i_k,
    input  logic [OCT_W-1:0]                i_octave,   // octave of the item in S1
    input  logic                            i_zero,     // item in S1 is in error
    output logic [COORD_BITS-1:0]           o_res,
    output logic                            o_sat
);

    localparam int c_in_w   = COORD_BITS + FRAC_BITS;
    localparam int c_k_w    = SCALE_FRAC + 1;
    localparam int c_prod_w = c_in_w + SCALE_FRAC + 1;
    // Room for the largest octave shift plus the rounding carry
    localparam int c_sh_w   = c_prod_w + (2 ** OCT_W - 1) + 1;
    localparam int c_rnd    = FRAC_BITS + SCALE_FRAC;
    localparam logic [c_sh_w-1:0] c_half = {{(c_sh_w-1){1'b0}}, 1'b1} << (c_rnd - 1);

    logic [c_in_w-1:0]   r_coord;
    logic [c_k_w-1:0]    r_k;
    logic [c_prod_w-1:0] r_prod;
    logic [c_sh_w-1:0]   w_scaled;
    logic [c_sh_w-1:0]   w_round;
    logic [c_sh_w-1:0]   w_res;
    logic                w_ovf;

    assign w_scaled = {{(c_sh_w-c_prod_w){1'b0}}, r_prod} << i_octave;
    assign w_round  = w_scaled + c_half;
    assign w_res    = w_round >> c_rnd;
    assign w_ovf    = |w_res[c_sh_w-1:COORD_BITS];

    // Three pipeline stages advancing together on the parent's enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coord <= '0;
            r_k     <= '0;
            r_prod  <= '0;
            o_res   <= '0;
            o_sat   <= 1'b0;
        end else if (i_en) begin
            r_coord <= i_coord;
            r_k     <= i_k;
            r_prod  <= {{(c_prod_w-c_in_w){1'b0}}, r_coord} * {{(c_prod_w-c_k_w){1'b0}}, r_k};
            if (i_zero) begin
                o_res <= '0;
                o_sat <= 1'b0;
            end else if (w_ovf) begin
                o_res <= '1;
                o_sat <= 1'b1;
            end else begin
                o_res <= w_res[COORD_BITS-1:0];
                o_sat <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/coordinate_restorer.sv
`default_nettype none
// ============================================================================
//  Module      : coordinate_restorer
//  Description : Maps (octave, sublevel) keypoint coordinates back to base
//                image pixels: out = round(in * 2^(oct + sub/L)). 3-stage
//                pipeline, single global enable, valid/ready on both sides.
//  Revision    : 1.0  initial release
// ============================================================================
module coordinate_restorer
    import scale_space_pkg::*;
#(
    parameter int COORD_BITS        = 16,
    parameter int FRAC_BITS         = 2,
    parameter int OCTAVES           = 4,
    parameter int LEVELS_PER_OCTAVE = 3,
    parameter int SCALE_FRAC        = 16,
    parameter int TAG_BITS          = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [COORD_BITS+FRAC_BITS-1:0]        in_x,
    input  logic [COORD_BITS+FRAC_BITS-1:0]        in_y,
    input  logic [$clog2(OCTAVES)-1:0]             in_octave,
    input  logic [$clog2(LEVELS_PER_OCTAVE)-1:0]   in_sublevel,
    input  logic [TAG_BITS-1:0]                    in_tag,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [COORD_BITS-1:0]                  out_x,
    output logic [COORD_BITS-1:0]                  out_y,
    output logic [TAG_BITS-1:0]                    out_tag,
    output logic                                   out_sat,
    output logic                                   out_err
);

    localparam int c_oct_w = $clog2(OCTAVES);
    localparam int c_sub_w = $clog2(LEVELS_PER_OCTAVE);
    localparam int c_k_w   = SCALE_FRAC + 1;

    logic                 w_en;
    logic                 w_in_err;
    logic [c_k_w-1:0]     w_k;
    logic [c_k_w-1:0]     w_k_tab [LEVELS_PER_OCTAVE];
    logic                 w_sat_x;
    logic                 w_sat_y;

    logic                 r_s0_valid;
    logic                 r_s0_err;
    logic [c_oct_w-1:0]   r_s0_oct;
    logic [TAG_BITS-1:0]  r_s0_tag;
    logic                 r_s1_valid;
    logic                 r_s1_err;
    logic [c_oct_w-1:0]   r_s1_oct;
    logic [TAG_BITS-1:0]  r_s1_tag;
    logic                 r_s2_valid;
    logic                 r_s2_err;
    logic [TAG_BITS-1:0]  r_s2_tag;

    // Whole pipeline moves whenever the output slot is empty or being drained
    assign w_en      = !r_s2_valid || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_s2_valid;
    assign out_tag   = r_s2_tag;
    assign out_err   = r_s2_err;
    assign out_sat   = w_sat_x | w_sat_y;

    assign w_in_err = (32'(in_octave) >= OCTAVES) || (32'(in_sublevel) >= LEVELS_PER_OCTAVE);

    // Per-sublevel scale constants fixed at elaboration
    for (genvar g = 0; g < LEVELS_PER_OCTAVE; g++) begin : g_k_table
        localparam longint unsigned c_k = scale_const(g, LEVELS_PER_OCTAVE, SCALE_FRAC);
        assign w_k_tab[g] = c_k[c_k_w-1:0];
    end

    // Select K for the incoming sublevel; out-of-range sublevels read zero
    always_comb begin
        w_k = '0;
        for (int j = 0; j < LEVELS_PER_OCTAVE; j++) begin
            if (32'(in_sublevel) == j) begin
                w_k = w_k_tab[j];
            end
        end
    end

    // Control sideband (valid, err, octave, tag) travelling with the data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_valid <= 1'b0;
            r_s0_err   <= 1'b0;
            r_s0_oct   <= '0;
            r_s0_tag   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_oct   <= '0;
            r_s1_tag   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_err   <= 1'b0;
            r_s2_tag   <= '0;
        end else if (w_en) begin
            r_s0_valid <= in_valid;
            r_s0_err   <= w_in_err;
            r_s0_oct   <= in_octave;
            r_s0_tag   <= in_tag;
            r_s1_valid <= r_s0_valid;
            r_s1_err   <= r_s0_err;
            r_s1_oct   <= r_s0_oct;
            r_s1_tag   <= r_s0_tag;
            r_s2_valid <= r_s1_valid;
            r_s2_err   <= r_s1_err;
            r_s2_tag   <= r_s1_tag;
        end
    end

    coord_scale_lane #(
        .COORD_BITS (COORD_BITS),
        .FRAC_BITS  (FRAC_BITS),
        .SCALE_FRAC (SCALE_FRAC),
        .OCT_W      (c_oct_w)
    ) u_lane_x (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_en),
        .i_coord  (in_x),
        .i_k      (w_k),
        .i_octave (r_s1_oct),
        .i_zero   (r_s1_err),
        .o_res    (out_x),
        .o_sat    (w_sat_x)
    );

    coord_scale_lane #(
        .COORD_BITS (COORD_BITS),
        .FRAC_BITS  (FRAC_BITS),
        .SCALE_FRAC (SCALE_FRAC),
        .OCT_W      (c_oct_w)
    ) u_lane_y (
        .clk      (clk),
        .rst      (rst),
        .i_en     (w_en),
        .i_coord  (in_y),
        .i_k      (w_k),
        .i_octave (r_s1_oct),
        .i_zero   (r_s1_err),
        .o_res    (out_y),
        .o_sat    (w_sat_y)
    );

endmodule
`default_nettype wire

// File: tb/tb_coordinate_restorer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coordinate_restorer
//  Description : Self-checking bench for coordinate_restorer: directed cases,
//                backpressure, reset flush and randomized traffic against a
//                reference model of out = round(in * 2^(oct + sub/L)).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_coordinate_restorer;

    localparam int c_fb  = 2;
    localparam int c_oct = 4;
    localparam int c_lv  = 3;
    localparam int c_sf  = 16;
    localparam longint c_max = 65535;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_x;
    logic [17:0] in_y;
    logic [1:0]  in_octave;
    logic [1:0]  in_sublevel;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;
    logic [15:0] out_y;
    logic [7:0]  out_tag;
    logic        out_sat;
    logic        out_err;

    coordinate_restorer u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_octave   (in_octave),
        .in_sublevel (in_sublevel),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_tag     (out_tag),
        .out_sat     (out_sat),
        .out_err     (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint x;
        longint y;
        longint tag;
        bit     sat;
        bit     err;
    } res_t;

    res_t   exp_q[$];
    res_t   out_log[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc      = 0;
    int     accept_cyc = 0;
    int     emit_cyc   = 0;
    bit     accepted;
    bit     have_snap  = 1'b0;
    longint snap;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // One axis: scale by 2^(oct + sub/L) with K rounded to SCALE_FRAC bits, round half up
    function automatic longint axis_ref(input longint c, input int oct, input int sub, output bit sat);
        longint k;
        longint v;
        longint r;
        k = longint'($floor((2.0 ** (real'(sub) / real'(c_lv))) * (2.0 ** c_sf) + 0.5));
        v = ((c * k) << oct) + (longint'(1) << (c_sf + c_fb - 1));
        r = v >> (c_sf + c_fb);
        sat = (r > c_max);
        if (sat) r = c_max;
        return r;
    endfunction

    function automatic res_t model(input longint x, input longint y, input int oct, input int sub, input longint tag);
        res_t r;
        bit   sx;
        bit   sy;
        r.tag = tag;
        if (oct >= c_oct || sub >= c_lv) begin
            r.x = 0; r.y = 0; r.sat = 1'b0; r.err = 1'b1;
        end else begin
            r.x = axis_ref(x, oct, sub, sx);
            r.y = axis_ref(y, oct, sub, sy);
            r.sat = sx | sy;
            r.err = 1'b0;
        end
        return r;
    endfunction

    task automatic drive(input longint x, input longint y, input int oct, input int sub, input int tag);
        in_valid    = 1'b1;
        in_x        = 18'(x);
        in_y        = 18'(y);
        in_octave   = 2'(oct);
        in_sublevel = 2'(sub);
        in_tag      = 8'(tag);
    endtask

    // One clock cycle: observe handshakes just after the negedge, then advance
    task automatic step();
        res_t e;
        res_t g;
        longint cur;
        #1;
        cur = longint'({out_valid, out_x, out_y, out_tag, out_sat, out_err});
        if (have_snap) check("stall_stable", cur, snap);
        have_snap = out_valid && !out_ready;
        snap = cur;
        if (out_valid && out_ready) begin
            g.x = out_x; g.y = out_y; g.tag = out_tag; g.sat = out_sat; g.err = out_err;
            out_log.push_back(g);
            emit_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("tag", g.tag, e.tag);
                check("x", g.x, e.x);
                check("y", g.y, e.y);
                check("sat", longint'(g.sat), longint'(e.sat));
                check("err", longint'(g.err), longint'(e.err));
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) begin
            exp_q.push_back(model(in_x, in_y, in_octave, in_sublevel, in_tag));
            accept_cyc = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send_single(input longint x, input longint y, input int oct, input int sub, input int tag);
        int guard;
        drive(x, y, oct, sub, tag);
        step();
        in_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 12) begin
            step();
            guard++;
        end
        check("drain_timeout", exp_q.size(), 0);
        check("latency", emit_cyc - accept_cyc, 3);
    endtask

    initial begin
        int idx;
        int n0;
        int guard;
        longint sx [5];
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0;
        in_octave = '0; in_sublevel = '0; in_tag = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_x", out_x, 0);
        check("rst_out_y", out_y, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_out_err", out_err, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed scaling cases
        send_single(40, 0, 0, 0, 8'h01);
        check("d_10_0", out_log[$].x, 10);
        check("d_10_0_y", out_log[$].y, 0);
        send_single(41, 8, 2, 0, 8'h02);
        check("d_oct2", out_log[$].x, 41);
        check("d_oct2_y", out_log[$].y, 8);
        send_single(42, 0, 0, 0, 8'h03);
        check("d_half_up", out_log[$].x, 11);

        drive(400, 400, 0, 1, 8'h11); step();
        drive(400, 0, 0, 2, 8'h22); step();
        in_valid = 1'b0;
        repeat (6) step();
        check("d_sub1_x", out_log[out_log.size()-2].x, 126);
        check("d_sub1_tag", out_log[out_log.size()-2].tag, 8'h11);
        check("d_sub2_x", out_log[$].x, 159);
        check("d_sub2_tag", out_log[$].tag, 8'h22);

        send_single(262140, 4, 3, 0, 8'h33);
        check("d_sat_x", out_log[$].x, 65535);
        check("d_sat_flag", out_log[$].sat, 1);
        check("d_nosat_y", out_log[$].y, 8);
        send_single(262140, 500, 1, 3, 8'h44);
        check("d_err_flag", out_log[$].err, 1);
        check("d_err_x", out_log[$].x, 0);
        check("d_err_y", out_log[$].y, 0);

        // Backpressure: five offers against a stalled output
        for (int i = 0; i < 5; i++) sx[i] = longint'($urandom_range(0, 4000));
        out_ready = 1'b0;
        idx = 0;
        n0 = out_log.size();
        for (int c = 0; c < 6; c++) begin
            if (idx < 5) drive(sx[idx], sx[4-idx], idx % 4, idx % 3, 8'h80 + idx);
            else in_valid = 1'b0;
            step();
            if (accepted) idx++;
        end
        check("bp_accepted", idx, 3);
        #1;
        check("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        guard = 0;
        while ((idx < 5 || exp_q.size() != 0) && guard < 30) begin
            if (idx < 5) drive(sx[idx], sx[4-idx], idx % 4, idx % 3, 8'h80 + idx);
            else in_valid = 1'b0;
            step();
            if (accepted) idx++;
            guard++;
        end
        check("bp_all_out", out_log.size() - n0, 5);

        // Reset with three items in flight
        for (int i = 0; i < 3; i++) begin
            drive(100 + i, 7, 1, i, 8'h40 + i);
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_flush_valid", out_valid, 0);
        check("rst_flush_x", out_x, 0);
        exp_q.delete();
        have_snap = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n0 = out_log.size();
        send_single(123, 45, 2, 1, 8'h5A);
        repeat (6) step();
        check("rst_single_count", out_log.size() - n0, 1);

        // Randomized traffic with random backpressure
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 1) == 0)
                    drive($urandom_range(0, 262143), $urandom_range(0, 262143),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
                else
                    drive($urandom_range(0, 4095), $urandom_range(0, 4095),
                          $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 255));
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            step();
            guard++;
        end
        check("rand_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
